gtfmac_vnc_lat_stats: RTL and testbench

- Latency-statistics accumulator in the GTF MAC latency-measurement clock domain.
- Consumes per-frame latency samples and keeps count, sum, min and max over a measurement window.
- On a snapshot request it freezes the window into a registered, packed stat bus and starts a new window.
- The stat bus is the `busin` source for the downstream bus clock-domain syncer, which carries it to the AXI-Lite register domain.
- The bus only changes on a single-cycle atomic update, so the downstream latch never sees a torn value.

---
 rtl/gtfmac_vnc_lat_stats_pkg.sv | 31 +++
 rtl/gtfmac_vnc_lat_stats_if.sv | 27 ++
 rtl/gtfmac_vnc_lat_accum.sv | 71 +++++++
 rtl/gtfmac_vnc_lat_stats.sv | 88 ++++++++
 tb/tb_gtfmac_vnc_lat_stats.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/gtfmac_vnc_lat_stats_pkg.sv
// Shared definitions for the latency-statistics snapshot bus.
// The register-domain decoder uses the same offsets to unpack stat_bus.
package gtfmac_vnc_lat_stats_pkg;

   localparam int DEF_SAMPLE_W = 16;
   localparam int DEF_CNT_W    = 32;
   localparam int DEF_SUM_W    = 48;
   localparam int DEF_SEQ_W    = 8;

   // Field offsets, LSB first: min, max, sum, count, seq
   localparam int MIN_OFS = 0;
   localparam int MAX_OFS = MIN_OFS + DEF_SAMPLE_W;
   localparam int SUM_OFS = MAX_OFS + DEF_SAMPLE_W;
   localparam int CNT_OFS = SUM_OFS + DEF_SUM_W;
   localparam int SEQ_OFS = CNT_OFS + DEF_CNT_W;
   localparam int STAT_W  = SEQ_OFS + DEF_SEQ_W;

   // Empty-window values: accumulator idle state and what a snapshot reports
   localparam logic [DEF_SAMPLE_W-1:0] EMPTY_ACC_MIN = '1;
   localparam logic [DEF_SAMPLE_W-1:0] EMPTY_ACC_MAX = '0;
   localparam logic [DEF_SAMPLE_W-1:0] EMPTY_REPORT  = '0;

   typedef struct packed {
      logic [DEF_SEQ_W-1:0]    seq;
      logic [DEF_CNT_W-1:0]    count;
      logic [DEF_SUM_W-1:0]    sum;
      logic [DEF_SAMPLE_W-1:0] max_v;
      logic [DEF_SAMPLE_W-1:0] min_v;
   } stat_snapshot_t;

endpackage

// File: rtl/gtfmac_vnc_lat_stats_if.sv
// Sample/control inputs and snapshot outputs of the latency-statistics block.
interface gtfmac_vnc_lat_stats_if #(
   parameter int SAMPLE_W = 16,
   parameter int CNT_W    = 32,
   parameter int SUM_W    = 48,
   parameter int SEQ_W    = 8
) ();

   logic                                  sample_valid;
   logic [SAMPLE_W-1:0]                   sample_value;
   logic                                  snapshot;
   logic                                  clear;
   logic [SEQ_W+CNT_W+SUM_W+2*SAMPLE_W-1:0] stat_bus;
   logic                                  snapshot_done;
   logic                                  overflow;

   modport master (
      output sample_valid, sample_value, snapshot, clear,
      input  stat_bus, snapshot_done, overflow
   );

   modport slave (
      input  sample_valid, sample_value, snapshot, clear,
      output stat_bus, snapshot_done, overflow
   );

endinterface

// File: rtl/gtfmac_vnc_lat_accum.sv
// Saturating count/sum and running min/max over one measurement window.
module gtfmac_vnc_lat_accum #(
   parameter int SAMPLE_W = 16,
   parameter int CNT_W    = 32,
   parameter int SUM_W    = 48
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                i_valid,
   input  logic [SAMPLE_W-1:0] i_sample,
   input  logic                i_restart,
   input  logic                i_flush,
   output logic [CNT_W-1:0]    o_count,
   output logic [SUM_W-1:0]    o_sum,
   output logic [SAMPLE_W-1:0] o_min,
   output logic [SAMPLE_W-1:0] o_max,
   output logic                o_sat
);

   logic [CNT_W-1:0]    r_count;
   logic [SUM_W-1:0]    r_sum;
   logic [SAMPLE_W-1:0] r_min;
   logic [SAMPLE_W-1:0] r_max;
   logic [SUM_W:0]      w_sum_ext;
   logic                w_cnt_full;

   // Next sum with carry, and the clamp condition for this cycle's sample
   always_comb begin
      w_sum_ext  = {1'b0, r_sum} + (SUM_W+1)'(i_sample);
      w_cnt_full = &r_count;
      o_sat      = i_valid & ~i_restart & ~i_flush & (w_cnt_full | w_sum_ext[SUM_W]);
   end

   // Window state: flush empties, restart seeds with this cycle's sample
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_count <= '0;
         r_sum   <= '0;
         r_min   <= '1;
         r_max   <= '0;
      end else if (i_flush) begin
         r_count <= '0;
         r_sum   <= '0;
         r_min   <= '1;
         r_max   <= '0;
      end else if (i_restart) begin
         if (i_valid) begin
            r_count <= CNT_W'(1);
            r_sum   <= SUM_W'(i_sample);
            r_min   <= i_sample;
            r_max   <= i_sample;
         end else begin
            r_count <= '0;
            r_sum   <= '0;
            r_min   <= '1;
            r_max   <= '0;
         end
      end else if (i_valid) begin
         r_count <= w_cnt_full ? r_count : r_count + CNT_W'(1);
         r_sum   <= w_sum_ext[SUM_W] ? '1 : w_sum_ext[SUM_W-1:0];
         if (i_sample < r_min) r_min <= i_sample;
         if (i_sample > r_max) r_max <= i_sample;
      end
   end

   assign o_count = r_count;
   assign o_sum   = r_sum;
   assign o_min   = r_min;
   assign o_max   = r_max;

endmodule

// File: rtl/gtfmac_vnc_lat_stats.sv
// Latency-statistics accumulator with atomic snapshot bus for the bus syncer.
module gtfmac_vnc_lat_stats
   import gtfmac_vnc_lat_stats_pkg::*;
#(
   parameter int SAMPLE_W = DEF_SAMPLE_W,
   parameter int CNT_W    = DEF_CNT_W,
   parameter int SUM_W    = DEF_SUM_W,
   parameter int SEQ_W    = DEF_SEQ_W
) (
   input  logic                  clk,
   input  logic                  reset,
   gtfmac_vnc_lat_stats_if.slave bus
);

   localparam int BUS_W = SEQ_W + CNT_W + SUM_W + 2*SAMPLE_W;

   logic [CNT_W-1:0]    w_count;
   logic [SUM_W-1:0]    w_sum;
   logic [SAMPLE_W-1:0] w_min;
   logic [SAMPLE_W-1:0] w_max;
   logic                w_sat;
   logic                w_restart;
   logic [SEQ_W-1:0]    w_seq_nxt;
   logic [SAMPLE_W-1:0] w_rep_min;
   logic [SAMPLE_W-1:0] w_rep_max;

   logic [BUS_W-1:0]    r_stat_bus;
   logic [SEQ_W-1:0]    r_seq;
   logic                r_done;
   logic                r_overflow;

   gtfmac_vnc_lat_accum #(
      .SAMPLE_W (SAMPLE_W),
      .CNT_W    (CNT_W),
      .SUM_W    (SUM_W)
   ) u_accum (
      .clk       (clk),
      .reset     (reset),
      .i_valid   (bus.sample_valid),
      .i_sample  (bus.sample_value),
      .i_restart (w_restart),
      .i_flush   (bus.clear),
      .o_count   (w_count),
      .o_sum     (w_sum),
      .o_min     (w_min),
      .o_max     (w_max),
      .o_sat     (w_sat)
   );

   // Clear outranks snapshot; an empty window reports min/max as zero
   always_comb begin
      w_restart = bus.snapshot & ~bus.clear;
      w_seq_nxt = r_seq + SEQ_W'(1);
      w_rep_min = w_min;
      w_rep_max = w_max;
      if (w_count == '0) begin
         w_rep_min = '0;
         w_rep_max = '0;
      end
   end

   // Snapshot register, sequence number, done pulse and sticky overflow
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_stat_bus <= '0;
         r_seq      <= '0;
         r_done     <= 1'b0;
         r_overflow <= 1'b0;
      end else if (bus.clear) begin
         r_stat_bus <= '0;
         r_seq      <= '0;
         r_done     <= 1'b0;
         r_overflow <= 1'b0;
      end else begin
         r_done     <= bus.snapshot;
         r_overflow <= r_overflow | w_sat;
         if (bus.snapshot) begin
            r_seq      <= w_seq_nxt;
            r_stat_bus <= {w_seq_nxt, w_count, w_sum, w_rep_max, w_rep_min};
         end
      end
   end

   assign bus.stat_bus      = r_stat_bus;
   assign bus.snapshot_done = r_done;
   assign bus.overflow      = r_overflow;

endmodule

// File: tb/tb_gtfmac_vnc_lat_stats.sv
// Directed self-checking bench: default build plus a narrow build for saturation.
module tb_gtfmac_vnc_lat_stats;
   import gtfmac_vnc_lat_stats_pkg::*;

   logic clk;
   logic reset;
   int   n_chk;
   int   n_pass;

   gtfmac_vnc_lat_stats_if #(
      .SAMPLE_W (DEF_SAMPLE_W), .CNT_W (DEF_CNT_W), .SUM_W (DEF_SUM_W), .SEQ_W (DEF_SEQ_W)
   ) if0 ();

   gtfmac_vnc_lat_stats_if #(
      .SAMPLE_W (8), .CNT_W (4), .SUM_W (8), .SEQ_W (4)
   ) if1 ();

   gtfmac_vnc_lat_stats #(
      .SAMPLE_W (DEF_SAMPLE_W), .CNT_W (DEF_CNT_W), .SUM_W (DEF_SUM_W), .SEQ_W (DEF_SEQ_W)
   ) u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (if0)
   );

   gtfmac_vnc_lat_stats #(
      .SAMPLE_W (8), .CNT_W (4), .SUM_W (8), .SEQ_W (4)
   ) u_dut_small (
      .clk   (clk),
      .reset (reset),
      .bus   (if1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic cyc(input logic v, input logic [15:0] val, input logic snap, input logic clr);
      if0.sample_valid = v;
      if0.sample_value = val;
      if0.snapshot     = snap;
      if0.clear        = clr;
      step();
   endtask

   task automatic cyc1(input logic v, input logic [7:0] val, input logic snap, input logic clr);
      if1.sample_valid = v;
      if1.sample_value = val;
      if1.snapshot     = snap;
      if1.clear        = clr;
      step();
   endtask

   task automatic chk_snap(input string tag, input int seq, input int cnt, input longint sum,
                           input int mx, input int mn);
      stat_snapshot_t s;
      s = if0.stat_bus;
      check({tag, ".seq"},   s.seq,   seq);
      check({tag, ".count"}, s.count, cnt);
      check({tag, ".sum"},   s.sum,   sum);
      check({tag, ".max"},   s.max_v, mx);
      check({tag, ".min"},   s.min_v, mn);
   endtask

   task automatic chk_snap1(input string tag, input int seq, input int cnt, input int sum,
                            input int mx, input int mn);
      logic [31:0] b;
      b = if1.stat_bus;
      check({tag, ".seq"},   b[31:28], seq);
      check({tag, ".count"}, b[27:24], cnt);
      check({tag, ".sum"},   b[23:16], sum);
      check({tag, ".max"},   b[15:8],  mx);
      check({tag, ".min"},   b[7:0],   mn);
   endtask

   task automatic do_reset();
      reset = 1'b0;
      #2;
      reset = 1'b1;
   endtask

   initial begin
      n_chk  = 0;
      n_pass = 0;
      reset  = 1'b0;
      if0.sample_valid = 1'b0; if0.sample_value = '0; if0.snapshot = 1'b0; if0.clear = 1'b0;
      if1.sample_valid = 1'b0; if1.sample_value = '0; if1.snapshot = 1'b0; if1.clear = 1'b0;
      #1;
      check("rst.bus",  if0.stat_bus, 0);
      check("rst.done", if0.snapshot_done, 0);
      check("rst.ovf",  if0.overflow, 0);
      #11;
      reset = 1'b1;
      step();

      // Empty window straight after reset
      cyc(0, 0, 1, 0);
      chk_snap("empty", 1, 0, 0, 0, 0);
      check("empty.done", if0.snapshot_done, 1);
      cyc(0, 0, 0, 0);
      check("empty.done_low", if0.snapshot_done, 0);

      // Samples 10, 30, 20, then snapshot
      do_reset();
      step();
      cyc(1, 10, 0, 0);
      cyc(1, 30, 0, 0);
      cyc(1, 20, 0, 0);
      cyc(0, 0, 0, 0);
      cyc(0, 0, 1, 0);
      chk_snap("basic", 1, 3, 60, 30, 10);
      check("basic.done", if0.snapshot_done, 1);
      cyc(0, 0, 0, 0);
      check("basic.done_low", if0.snapshot_done, 0);
      chk_snap("basic.hold", 1, 3, 60, 30, 10);

      // Sample coincident with snapshot starts the next window
      cyc(1, 7, 1, 0);
      chk_snap("coinc1", 2, 0, 0, 0, 0);
      cyc(0, 0, 0, 0);
      cyc(0, 0, 0, 0);
      cyc(0, 0, 1, 0);
      chk_snap("coinc2", 3, 1, 7, 7, 7);

      // Back-to-back snapshots
      cyc(1, 9, 0, 0);
      cyc(1, 5, 1, 0);
      chk_snap("b2b1", 4, 1, 9, 9, 9);
      check("b2b1.done", if0.snapshot_done, 1);
      cyc(0, 0, 1, 0);
      chk_snap("b2b2", 5, 1, 5, 5, 5);
      check("b2b2.done", if0.snapshot_done, 1);
      cyc(0, 0, 0, 0);
      check("b2b.done_low", if0.snapshot_done, 0);

      // Clear and snapshot together after five samples; clear wins, sample dropped
      for (int i = 1; i <= 5; i++) cyc(1, 16'(i), 0, 0);
      cyc(1, 50, 1, 1);
      check("clr.bus",  if0.stat_bus, 0);
      check("clr.done", if0.snapshot_done, 0);
      check("clr.ovf",  if0.overflow, 0);
      cyc(0, 0, 1, 0);
      chk_snap("clr.next", 1, 0, 0, 0, 0);

      // Sequence wrap with one sample of 4 in every window
      for (int i = 0; i < 254; i++) cyc(1, 4, 1, 0);
      chk_snap("wrap255", 255, 1, 4, 4, 4);
      cyc(1, 4, 1, 0);
      chk_snap("wrap0", 0, 1, 4, 4, 4);
      check("wrap0.done", if0.snapshot_done, 1);

      // Async reset in mid-window, away from the clock edge
      if0.sample_valid = 1'b0; if0.snapshot = 1'b0;
      #2;
      reset = 1'b0;
      #1;
      check("arst.bus",  if0.stat_bus, 0);
      check("arst.done", if0.snapshot_done, 0);
      check("arst.ovf",  if0.overflow, 0);
      step();
      #2;
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cyc(0, 0, 0, 0);
         check("arst.no_done", if0.snapshot_done, 0);
      end
      cyc(0, 0, 1, 0);
      chk_snap("arst.next", 1, 0, 0, 0, 0);

      // Narrow build: count saturates at 15
      for (int i = 0; i < 15; i++) cyc1(1, 1, 0, 0);
      check("sat.ovf_before", if1.overflow, 0);
      cyc1(1, 1, 0, 0);
      check("sat.ovf_set", if1.overflow, 1);
      cyc1(1, 1, 0, 0);
      cyc1(0, 0, 1, 0);
      chk_snap1("sat.snap", 1, 15, 17, 1, 1);
      cyc1(0, 0, 0, 0);
      cyc1(0, 0, 0, 0);
      check("sat.ovf_sticky", if1.overflow, 1);
      cyc1(0, 0, 0, 1);
      check("sat.ovf_clr", if1.overflow, 0);

      // Narrow build: sum saturates at 255
      cyc1(1, 200, 0, 0);
      check("sum.ovf_before", if1.overflow, 0);
      cyc1(1, 100, 0, 0);
      check("sum.ovf_set", if1.overflow, 1);
      cyc1(0, 0, 1, 0);
      chk_snap1("sum.snap", 1, 2, 255, 200, 100);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
